// File: rtl/video_timing_monitor.sv
// video_timing_monitor
// Measures the timing of an incoming pixel stream (line length, active width,
// frame length, active height), sums active pixels per frame, and runs a lock
// state machine that reports when timing has been stable for LOCK_FRAMES
// consecutive complete frames. PAL/scandoubled detection is derived from the
// latched frame length and is only reported while locked.
module video_timing_monitor #(
    parameter int LOCK_FRAMES = 2,
    parameter int CW          = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          hblank,
    input  logic          vblank,
    input  logic [7:0]    video,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic [15:0]   frame_sum,
    output logic          frame_strobe,
    output logic          locked,
    output logic          pal_det,
    output logic          sd_det,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [2:0]    LOCK_TARGET  = 3'(LOCK_FRAMES);
    localparam logic [CW-1:0] PAL_LINES    = CW'(312);
    localparam logic [CW-1:0] PAL_SD_LINES = CW'(624);
    localparam logic [CW-1:0] SD_MIN_LINES = CW'(400);

    state_t        state_q, state_d;
    logic [2:0]    match_q, match_d;
    logic          first_q, first_d;

    logic          hs_prev, vs_prev;
    logic [CW-1:0] h_cnt, ha_cnt;
    logic [CW-1:0] last_len, last_act;
    logic [CW-1:0] first_len;
    logic          have_first;
    logic [CW-1:0] v_cnt, va_cnt;
    logic [15:0]   sum;
    logic          frame_bad;

    logic          hs_rise, vs_rise;
    logic [15:0]   pix_val;
    logic          line_bad;
    logic [CW-1:0] h_inc, ha_inc;
    logic [CW-1:0] v_line, va_line;
    logic [CW-1:0] end_h, end_ha;
    logic          end_bad;
    logic          consistent;

    // Edge detection, saturating increments and the view of the frame that is
    // ending on this sample (an hsync rise in the same sample closes its line
    // into the ending frame before the vsync rise is handled).
    always_comb begin
        hs_rise    = ce_pix & hsync & ~hs_prev;
        vs_rise    = ce_pix & vsync & ~vs_prev;
        pix_val    = (!hblank && !vblank) ? {8'd0, video} : 16'd0;
        h_inc      = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + CNT_ONE;
        ha_inc     = (ha_cnt == CNT_MAX) ? ha_cnt : ha_cnt + CNT_ONE;
        line_bad   = hs_rise & ((h_cnt == CNT_MAX) |
                                (have_first & (h_cnt != first_len)));
        v_line     = (hs_rise && v_cnt != CNT_MAX) ? v_cnt + CNT_ONE : v_cnt;
        va_line    = (hs_rise && !vblank && va_cnt != CNT_MAX) ? va_cnt + CNT_ONE : va_cnt;
        end_h      = hs_rise ? h_cnt : last_len;
        end_ha     = hs_rise ? ha_cnt : last_act;
        end_bad    = frame_bad | line_bad | (v_line == '0);
        consistent = !end_bad && (first_q || (end_h == h_total && v_line == v_total));
    end

    // Lock state machine: next state, match counter and first-frame flag.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        first_d = first_q;
        case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = MEASURE;
                    match_d = 3'd0;
                    first_d = 1'b1;
                end
            end
            MEASURE: begin
                if (vs_rise) begin
                    first_d = 1'b0;
                    if (consistent) begin
                        match_d = match_q + 3'd1;
                    end else begin
                        match_d = end_bad ? 3'd0 : 3'd1;
                    end
                    if (match_d >= LOCK_TARGET) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (vs_rise && !consistent)) begin
                    state_d = MEASURE;
                    match_d = 3'd0;
                end
            end
            default: begin
                state_d = SEARCH;
                match_d = 3'd0;
                first_d = 1'b0;
            end
        endcase
    end

    // State register; locked follows the state entered on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            match_q <= 3'd0;
            first_q <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            first_q <= first_d;
            locked  <= (state_d == LOCKED);
        end
    end

    // Line/frame counters and the latched per-frame measurements.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev      <= 1'b1;
            vs_prev      <= 1'b1;
            h_cnt        <= '0;
            ha_cnt       <= '0;
            last_len     <= '0;
            last_act     <= '0;
            first_len    <= '0;
            have_first   <= 1'b0;
            v_cnt        <= '0;
            va_cnt       <= '0;
            sum          <= 16'd0;
            frame_bad    <= 1'b0;
            h_total      <= '0;
            h_active     <= '0;
            v_total      <= '0;
            v_active     <= '0;
            frame_sum    <= 16'd0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (ce_pix) begin
                hs_prev <= hsync;
                vs_prev <= vsync;
                if (hs_rise) begin
                    h_cnt    <= CNT_ONE;
                    ha_cnt   <= {{(CW-1){1'b0}}, ~hblank};
                    last_len <= h_cnt;
                    last_act <= ha_cnt;
                    if (!have_first) begin
                        first_len  <= h_cnt;
                        have_first <= 1'b1;
                    end
                end else begin
                    h_cnt  <= h_inc;
                    ha_cnt <= hblank ? ha_cnt : ha_inc;
                end
                if (vs_rise) begin
                    v_cnt      <= '0;
                    va_cnt     <= '0;
                    sum        <= pix_val;
                    frame_bad  <= 1'b0;
                    have_first <= 1'b0;
                    if (state_q != SEARCH) begin
                        h_total      <= end_h;
                        h_active     <= end_ha;
                        v_total      <= v_line;
                        v_active     <= va_line;
                        frame_sum    <= sum;
                        frame_strobe <= 1'b1;
                    end
                end else begin
                    v_cnt     <= v_line;
                    va_cnt    <= va_line;
                    sum       <= sum + pix_val;
                    frame_bad <= frame_bad | line_bad;
                end
            end
        end
    end

    assign pal_det   = locked && (v_total == PAL_LINES || v_total == PAL_SD_LINES);
    assign sd_det    = locked && (v_total >= SD_MIN_LINES);
    assign state_dbg = state_q;

endmodule
